// File: rtl/uart_enigma_ctrl.sv
// uart_enigma_ctrl: byte sequencer between a UART and the Enigma cipher core.
//   Letters go through the cipher and are sent back, '#'+3 letters loads the
//   rotor positions, whitespace is echoed, anything else is answered with '?'.
// Ports: rx_valid/rx_data (UART receive), tx_valid/tx_data/tx_active (UART
//   transmit, owned exclusively), enc_req/enc_in/enc_ack/enc_out (cipher
//   handshake), cfg_we/cfg_addr/cfg_data (rotor write), busy, overrun (sticky).
module uart_enigma_ctrl #(
  parameter logic [7:0] CMD_CHAR    = 8'h23,
  parameter int         ENC_TIMEOUT = 1024,
  parameter int         TXR_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_active,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       enc_req,
  output logic [4:0] enc_in,
  input  logic       enc_ack,
  input  logic [4:0] enc_out,
  output logic       cfg_we,
  output logic [1:0] cfg_addr,
  output logic [4:0] cfg_data,
  output logic       busy,
  output logic       overrun
);

  // One counter serves both the cipher timeout and the tx_active rise timeout.
  localparam int TMO_MAX = (ENC_TIMEOUT > TXR_TIMEOUT) ? ENC_TIMEOUT : TXR_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX) + 1;
  localparam logic [TMO_W-1:0] ENC_LAST = TMO_W'(ENC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TXR_LAST = TMO_W'(TXR_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [7:0] CH_QUERY = 8'h3F;
  localparam logic [7:0] CH_BANG  = 8'h21;

  typedef enum logic [2:0] {
    IDLE, ENC_REQ, CMD, TX_LAUNCH, TX_RISE, TX_FALL
  } state_t;

  state_t           state_q, state_d;
  logic             enc_req_q, enc_req_d;
  logic [4:0]       enc_in_q, enc_in_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             cfg_we_q, cfg_we_d;
  logic [1:0]       cfg_addr_q, cfg_addr_d;
  logic [4:0]       cfg_data_q, cfg_data_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       cmd_idx_q, cmd_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic       rx_letter;
  logic       rx_echo;
  logic [4:0] rx_idx;

  assign rx_letter = ((rx_data >= 8'h41) && (rx_data <= 8'h5A)) ||
                     ((rx_data >= 8'h61) && (rx_data <= 8'h7A));
  assign rx_echo   = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  // 'A' and 'a' both have low five bits 1, so one subtract covers either case.
  assign rx_idx    = rx_data[4:0] - 5'd1;

  always_comb begin
    state_d    = state_q;
    enc_req_d  = enc_req_q;
    enc_in_d   = enc_in_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    cfg_we_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    overrun_d  = overrun_q;
    cmd_idx_d  = cmd_idx_q;
    tmo_d      = tmo_q;

    if (rx_valid && (state_q != IDLE) && (state_q != CMD)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_letter) begin
            enc_in_d  = rx_idx;
            enc_req_d = 1'b1;
            tmo_d     = '0;
            state_d   = ENC_REQ;
          end else if (rx_data == CMD_CHAR) begin
            cmd_idx_d = 2'd0;
            state_d   = CMD;
          end else if (rx_echo) begin
            tx_data_d = rx_data;
            state_d   = TX_LAUNCH;
          end else begin
            tx_data_d = CH_QUERY;
            state_d   = TX_LAUNCH;
          end
        end
      end
      ENC_REQ: begin
        if (enc_ack) begin
          enc_req_d = 1'b0;
          tx_data_d = 8'h41 + {3'b000, enc_out};
          // Launch straight from the ack edge when the line is free, so the
          // reply strobe follows the ack by a single cycle.
          if (!tx_active) begin
            tx_valid_d = 1'b1;
            tmo_d      = '0;
            state_d    = TX_RISE;
          end else begin
            state_d    = TX_LAUNCH;
          end
        end else if (tmo_q == ENC_LAST) begin
          enc_req_d = 1'b0;
          tx_data_d = CH_QUERY;
          state_d   = TX_LAUNCH;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      CMD: begin
        if (rx_valid) begin
          if (rx_letter) begin
            cfg_we_d   = 1'b1;
            cfg_addr_d = cmd_idx_q;
            cfg_data_d = rx_idx;
            cmd_idx_d  = cmd_idx_q + 2'd1;
            if (cmd_idx_q == 2'd2) begin
              tx_data_d = CH_BANG;
              state_d   = TX_LAUNCH;
            end
          end else begin
            tx_data_d = CH_QUERY;
            state_d   = TX_LAUNCH;
          end
        end
      end
      TX_LAUNCH: begin
        if (!tx_active) begin
          tx_valid_d = 1'b1;
          tmo_d      = '0;
          state_d    = TX_RISE;
        end
      end
      TX_RISE: begin
        if (tx_active)              state_d = TX_FALL;
        else if (tmo_q == TXR_LAST) state_d = IDLE;
        else                        tmo_d   = tmo_q + TMO_ONE;
      end
      TX_FALL: begin
        if (!tx_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      enc_req_q  <= 1'b0;
      enc_in_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cmd_idx_q  <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      enc_req_q  <= enc_req_d;
      enc_in_q   <= enc_in_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cfg_we_q   <= cfg_we_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      cmd_idx_q  <= cmd_idx_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign enc_req  = enc_req_q;
  assign enc_in   = enc_in_q;
  assign cfg_we   = cfg_we_q;
  assign cfg_addr = cfg_addr_q;
  assign cfg_data = cfg_data_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/uart_enigma_ctrl.md
Name: uart_enigma_ctrl

Overview:
Sequencer between the byte UART (clk/rst, transmit/tx_byte, received/rx_byte, is_transmitting) and the Enigma cipher core. It classifies each received byte:
- Letters are sent through the cipher core and the result is transmitted back.
- A command prefix loads the three rotor positions.
- Everything else gets a fixed reply.

It owns the UART transmitter exclusively and serialises one reply per accepted byte.

Parameters:
CMD_CHAR, 8'h23, byte ('#') that opens a rotor-load command
ENC_TIMEOUT, 1024, cycles to wait for enc_ack before abandoning a request (must be >=2)
TXR_TIMEOUT, 8, cycles to wait for tx_active to rise after tx_valid before abandoning the send

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
rx_valid  in  1  UART received strobe, 1 cycle
rx_data  in  8  UART received byte, valid with rx_valid
tx_active  in  1  UART is_transmitting
tx_valid  out  1  UART transmit strobe, 1-cycle pulse
tx_data  out  8  byte to transmit, held from tx_valid until the send completes
enc_req  out  1  cipher request, level
enc_in  out  5  letter index 0..25, stable while enc_req=1
enc_ack  in  1  cipher done, 1-cycle pulse
enc_out  in  5  ciphered index, valid with enc_ack
cfg_we  out  1  rotor position write strobe, 1 cycle
cfg_addr  out  2  rotor select 0..2
cfg_data  out  5  rotor position 0..25
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: a byte arrived while busy and was dropped

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE.
- Command index 0.
- Timeout counter 0.
- rst_n low mid-operation aborts immediately:
  - enc_req drops.
  - No further tx_valid or cfg_we is issued.
  - An in-flight UART frame is not the block's concern.

States: IDLE, ENC_REQ, CMD, TX_LAUNCH, TX_RISE, TX_FALL.

IDLE, on rx_valid (byte b latched, same edge):
- 'A'-'Z' (0x41-0x5A) or 'a'-'z' (0x61-0x7A): idx = b-0x41 or b-0x61 -> ENC_REQ; enc_req=1 from the next cycle.
- b==CMD_CHAR: cmd index=0 -> CMD.
- 0x20, 0x0D, 0x0A: tx byte = b -> TX_LAUNCH (echo).
- Any other byte: tx byte = 0x3F '?' -> TX_LAUNCH.

ENC_REQ:
- Hold enc_req and enc_in.
- On enc_ack: drop enc_req the following cycle; tx byte = enc_out+0x41 -> TX_LAUNCH.
- On timeout (ENC_TIMEOUT cycles without ack): drop enc_req; tx byte = '?' -> TX_LAUNCH.
- An enc_ack in IDLE or any other state is ignored.

CMD (waits for 3 bytes; no timeout):
- Letter (either case): cfg_we=1 for 1 cycle with cfg_addr = cmd index and cfg_data = letter idx; increment cmd index.
- After the write with index 2: tx byte = 0x21 '!' -> TX_LAUNCH.
- Non-letter byte: no write; tx byte = '?' -> TX_LAUNCH. Rotors already written stay written.

TX_LAUNCH:
- Wait while tx_active=1.
- When tx_active=0: tx_valid=1 for exactly 1 cycle -> TX_RISE.

TX_RISE:
- Wait for tx_active=1 -> TX_FALL.
- If tx_active is not seen high within TXR_TIMEOUT cycles -> IDLE (drop).

TX_FALL:
- On tx_active=0 -> IDLE.
- Next byte accepted no earlier than the cycle after returning to IDLE.

Overrun and strobes:
- rx_valid in any state except IDLE and CMD sets overrun; the byte is dropped. overrun is cleared only by reset.
- rx_valid in CMD during the cfg_we cycle is not possible, since UART bytes arrive far apart; no requirement.
- tx_valid and cfg_we are never asserted in the same cycle.
- tx_valid is never asserted twice per accepted byte.

Latency:
- rx_valid (edge N) to enc_req=1 at N+1.
- enc_ack (edge M) to tx_valid at M+1 if tx_active=0.

Test Plan:
1. Reset, send 0x41 'A'; core model acks after 3 cycles with enc_out=5 -> enc_in=0 while enc_req=1, one tx_valid with tx_data=0x46 'F', busy returns low after tx_active falls.
2. Send 0x7A 'z', ack enc_out=0 -> enc_in=25, tx_data=0x41.
3. Send '#','C','Q','Z' -> three cfg_we pulses: (addr0,data2), (addr1,data16), (addr2,data25); then tx_data=0x21. Send '#','B','5' -> one write (addr0,data1), then tx_data=0x3F, back to IDLE.
4. Send 0x20 -> echo 0x20. Send 0x7E -> tx_data=0x3F. No enc_req in either case.
5. Send 'M' with core never acking -> enc_req high for exactly ENC_TIMEOUT cycles, then tx_data=0x3F. A late enc_ack afterwards is ignored.
6. Send 'A' and, while in ENC_REQ, strobe rx_valid with 'B' -> overrun=1 and only one enc_req/tx_valid. Assert rst_n=0 during TX_FALL -> all outputs 0, overrun cleared, next 'A' handled normally.
